imem_boot_loader: RTL

- Byte-stream program loader: the writer side of the instruction memory that the rvseed core fetches from.
- Receives a framed program image on a valid/ready byte interface, assembles little-endian words and writes them to the instruction memory write port.
- Holds the core in reset until a complete frame with a correct checksum has been written.
- Replaces the simulation-only backdoor memory preload with a synthesizable load path. Sits beside inst_mem at rvseed top level.

---
 rtl/imem_boot_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: frames bytes into words, writes instruction memory, gates core reset.
// Optional IMEM_BOOT_BYPASS_EN: reset lands in DONE so a backdoor-preloaded image runs immediately.
module imem_boot_loader #(
  parameter int          CPU_WIDTH  = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [CPU_WIDTH-1:0]  imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           word_cnt
);

  localparam int NB   = CPU_WIDTH / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

`ifdef IMEM_BOOT_BYPASS_EN
  localparam state_t RST_STATE = DONE;
  localparam logic   RST_HOLD  = 1'b0;
  localparam logic   RST_DONE  = 1'b1;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_HOLD  = 1'b1;
  localparam logic   RST_DONE  = 1'b0;
`endif

  state_t                state, state_nxt;
  logic [15:0]           len;
  logic [7:0]            csum;
  logic [IDXW-1:0]       byte_idx;
  logic [CPU_WIDTH-1:0]  asm_word, word_full;
  logic                  fire, last_byte, len_big, is_magic;

  assign fire      = rx_valid && rx_ready;
  assign last_byte = (byte_idx == IDXW'(NB - 1));
  assign len_big   = {1'b0, rx_data, len[7:0]} > MAX_LEN;
  assign is_magic  = (rx_data == MAGIC);

  // Completed word = bytes assembled so far plus the byte on the wire now.
  always_comb begin
    word_full = asm_word;
    word_full[8*byte_idx +: 8] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fire) begin
      unique case (state)
        IDLE, DONE, ERR: if (is_magic) state_nxt = LEN0;
        LEN0:            state_nxt = LEN1;
        LEN1: begin
          if (len_big)                            state_nxt = ERR;
          else if ({rx_data, len[7:0]} == 16'd0)  state_nxt = CSUM;
          else                                    state_nxt = DATA;
        end
        DATA: if (last_byte && (word_cnt + 16'd1 == len)) state_nxt = CSUM;
        CSUM: state_nxt = (csum == rx_data) ? DONE : ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Loader never back-pressures; the output write registers are separate from asm_word.
  always_comb begin
    rx_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      csum       <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= RST_HOLD;
      load_done  <= RST_DONE;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (fire) begin
        unique case (state)
          IDLE, DONE, ERR: if (is_magic) begin
            csum      <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
          end
          LEN0: begin
            len[7:0] <= rx_data;
            csum     <= csum ^ rx_data;
          end
          LEN1: begin
            len[15:8] <= rx_data;
            csum      <= csum ^ rx_data;
            if (len_big) load_err <= 1'b1;
          end
          DATA: begin
            csum <= csum ^ rx_data;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              imem_wdata <= word_full;
              word_cnt   <= word_cnt + 16'd1;
              byte_idx   <= '0;
            end else begin
              asm_word[8*byte_idx +: 8] <= rx_data;
              byte_idx <= byte_idx + IDXW'(1);
            end
          end
          CSUM: begin
            if (csum == rx_data) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
